// File: rtl/fifo_serial_tx_if.sv
// Read-port bundle between a first-word-fall-through FIFO and its consumer.
// The consumer (master) issues the pop strobe; the FIFO (slave) presents head word and empty flag.
interface fifo_serial_tx_if #(
   parameter int bits_per_word = 8
) ();
   logic                     empty;
   logic [bits_per_word-1:0] read_data;
   logic                     read;

   modport master (
      input  empty,
      input  read_data,
      output read
   );

   modport slave (
      output empty,
      output read_data,
      input  read
   );
endinterface

// File: rtl/fifo_serial_tx.sv
// Drains a FWFT FIFO and shifts each word out as an async serial frame
// (start bit, data LSB first, stop bit) with back-to-back frames while data remains.
module fifo_serial_tx #(
   parameter int bits_per_word = 8,
   parameter int clks_per_bit  = 4
) (
   input  logic              clk,
   input  logic              areset,
   fifo_serial_tx_if.master  fifo_rd,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);
   localparam int tick_w = (clks_per_bit  > 1) ? $clog2(clks_per_bit)  : 1;
   localparam int bit_w  = (bits_per_word > 1) ? $clog2(bits_per_word) : 1;
   localparam logic [tick_w-1:0] tick_last = tick_w'(clks_per_bit - 1);
   localparam logic [bit_w-1:0]  bit_last  = bit_w'(bits_per_word - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                   state_reg, state_next;
   logic [bits_per_word-1:0] shift_reg, shift_next;
   logic [bits_per_word-1:0] shift_dn;
   logic [bit_w-1:0]         bit_cnt_reg, bit_cnt_next;
   logic [tick_w-1:0]        tick_cnt_reg, tick_cnt_next;
   logic                     tx_reg, tx_next;
   logic                     last_tick;
   logic                     last_stop;
   logic                     pop;

   genvar gi;
   generate
      for (gi = 0; gi < bits_per_word - 1; gi++) begin : g_shift
         assign shift_dn[gi] = shift_reg[gi+1];
      end
   endgenerate
   assign shift_dn[bits_per_word-1] = 1'b0;

   assign last_tick  = (tick_cnt_reg == tick_last);
   assign last_stop  = (state_reg == STOP) && last_tick;
   // Pop only at a frame boundary so a word arriving mid-frame waits its turn.
   assign pop        = ~areset & ~fifo_rd.empty & ((state_reg == IDLE) | last_stop);

   assign fifo_rd.read = pop;
   assign tx           = tx_reg;
   assign busy         = (state_reg != IDLE);
   assign frame_done   = last_stop;

   always_comb begin
      state_next    = state_reg;
      shift_next    = shift_reg;
      bit_cnt_next  = bit_cnt_reg;
      tick_cnt_next = last_tick ? '0 : tick_cnt_reg + tick_w'(1);
      tx_next       = 1'b1;

      case (state_reg)
         IDLE: tick_cnt_next = '0;
         START: begin
            if (last_tick) state_next = DATA;
         end
         DATA: begin
            if (last_tick) begin
               shift_next   = shift_dn;
               bit_cnt_next = bit_cnt_reg + bit_w'(1);
               if (bit_cnt_reg == bit_last) begin
                  bit_cnt_next = '0;
                  state_next   = STOP;
               end
            end
         end
         STOP: begin
            if (last_tick) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (pop) begin
         shift_next    = fifo_rd.read_data;
         tick_cnt_next = '0;
         bit_cnt_next  = '0;
         state_next    = START;
      end

      // Line level follows the state being entered, so tx flips exactly on bit boundaries.
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = shift_next[0];
         default: tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         state_reg    <= IDLE;
         shift_reg    <= '0;
         bit_cnt_reg  <= '0;
         tick_cnt_reg <= '0;
         tx_reg       <= 1'b1;
      end else begin
         state_reg    <= state_next;
         shift_reg    <= shift_next;
         bit_cnt_reg  <= bit_cnt_next;
         tick_cnt_reg <= tick_cnt_next;
         tx_reg       <= tx_next;
      end
   end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: two instances (4 and 1 clocks per bit) fed from queue-modelled FIFOs,
// checked each cycle against a frame-position reference model plus table-driven frame vectors.
module tb_fifo_serial_tx;
   localparam int BPW = 8;

   logic       clk = 1'b0;
   logic       areset = 1'b1;
   logic [1:0] tx_w, busy_w, done_w, read_w;

   fifo_serial_tx_if #(.bits_per_word(BPW)) ifc0 ();
   fifo_serial_tx_if #(.bits_per_word(BPW)) ifc1 ();

   fifo_serial_tx #(.bits_per_word(BPW), .clks_per_bit(4)) dut (
      .clk        (clk),
      .areset     (areset),
      .fifo_rd    (ifc0.master),
      .tx         (tx_w[0]),
      .busy       (busy_w[0]),
      .frame_done (done_w[0])
   );

   fifo_serial_tx #(.bits_per_word(BPW), .clks_per_bit(1)) dut1 (
      .clk        (clk),
      .areset     (areset),
      .fifo_rd    (ifc1.master),
      .tx         (tx_w[1]),
      .busy       (busy_w[1]),
      .frame_done (done_w[1])
   );

   assign read_w[0] = ifc0.read;
   assign read_w[1] = ifc1.read;

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic [9:0] frame;   // bit k = k-th serial bit sent (start first)
      int         idx;
   } vec_t;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit         active[2];
   int         pos[2];
   logic [7:0] word[2];
   bit         exp_read[2];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;

   function automatic int cpb(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   function automatic int flen(input int i);
      return (BPW + 2) * cpb(i);
   endfunction

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   function automatic logic bit_at(input int i, input int p);
      int b;
      b = p / cpb(i);
      if (b == 0) return 1'b0;
      if (b <= BPW) return word[i][b-1];
      return 1'b1;
   endfunction

   task automatic drive_pins();
      ifc0.empty     = (q0.size() == 0);
      ifc0.read_data = (q0.size() != 0) ? q0[0] : 8'h00;
      ifc1.empty     = (q1.size() == 0);
      ifc1.read_data = (q1.size() != 0) ? q1[0] : 8'h00;
   endtask

   task automatic push(input int i, input logic [7:0] d);
      if (i == 0) q0.push_back(d);
      else        q1.push_back(d);
      drive_pins();
   endtask

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d cycle=%0d actual=%0h required=%0h", name, i, cyc, act, exp);
      end
   endtask

   // Sample on the falling edge; optionally compare every output against the model.
   task automatic sample(input bit check_model);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         exp_read[i] = !areset && (qsize(i) != 0) && (!active[i] || pos[i] == flen(i) - 1);
         if (check_model) begin
            chk("model_tx",   i, tx_w[i],   active[i] ? bit_at(i, pos[i]) : 1'b1);
            chk("model_busy", i, busy_w[i], active[i]);
            chk("model_done", i, done_w[i], active[i] && pos[i] == flen(i) - 1);
            chk("model_read", i, read_w[i], exp_read[i]);
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (areset) begin
            active[i] = 1'b0;
         end else if (exp_read[i]) begin
            word[i]   = (i == 0) ? q0.pop_front() : q1.pop_front();
            pos[i]    = 0;
            active[i] = 1'b1;
         end else if (active[i]) begin
            pos[i]++;
            if (pos[i] >= flen(i)) active[i] = 1'b0;
         end
      end
      drive_pins();
   endtask

   task automatic run_frame(input int i, input logic [9:0] frame);
      sample(1);
      chk("pop_pulse", i, read_w[i], 1);
      advance();
      for (int k = 0; k < flen(i); k++) begin
         sample(1);
         chk("frame_tx",   i, tx_w[i],   frame[k / cpb(i)]);
         chk("frame_done", i, done_w[i], (k == flen(i) - 1));
         chk("frame_busy", i, busy_w[i], 1);
         advance();
      end
   endtask

   task automatic idle_check(input int i, input int n);
      for (int k = 0; k < n; k++) begin
         sample(1);
         chk("idle_tx",   i, tx_w[i],   1);
         chk("idle_read", i, read_w[i], 0);
         chk("idle_busy", i, busy_w[i], 0);
         advance();
      end
   endtask

   initial begin
      vec_t       tbl[7];
      logic [9:0] f01, fff, f5a, f33;
      int         guard;

      tbl[0] = '{data: 8'hA5, frame: 10'b1101001010, idx: 0};
      tbl[1] = '{data: 8'h3C, frame: 10'b1001111000, idx: 0};
      tbl[2] = '{data: 8'h81, frame: 10'b1100000010, idx: 0};
      tbl[3] = '{data: 8'h80, frame: 10'b1100000000, idx: 1};
      tbl[4] = '{data: 8'hA5, frame: 10'b1101001010, idx: 1};
      tbl[5] = '{data: 8'h5A, frame: 10'b1010110100, idx: 0};
      tbl[6] = '{data: 8'hFF, frame: 10'b1111111110, idx: 1};
      f01 = 10'b1000000010;
      fff = 10'b1111111110;
      f5a = 10'b1010110100;
      f33 = 10'b1001100110;

      active[0] = 1'b0; active[1] = 1'b0;
      pos[0] = 0; pos[1] = 0;
      drive_pins();

      // Reset state
      repeat (2) begin sample(0); advance(); end
      sample(1);
      for (int i = 0; i < 2; i++) begin
         chk("rst_tx",   i, tx_w[i],   1);
         chk("rst_busy", i, busy_w[i], 0);
         chk("rst_done", i, done_w[i], 0);
         chk("rst_read", i, read_w[i], 0);
      end
      advance();
      areset = 1'b0;

      // Idle hold with empty FIFO
      idle_check(0, 100);

      // Table vectors, 5 idle cycles between words (late arrival after an emptied FIFO)
      for (int v = 0; v < 7; v++) begin
         push(tbl[v].idx, tbl[v].data);
         run_frame(tbl[v].idx, tbl[v].frame);
         idle_check(tbl[v].idx, 5);
      end

      // Back-to-back: second pop on the last stop cycle, no gap
      push(0, 8'h01);
      push(0, 8'hFF);
      sample(1);
      chk("b2b_pop0", 0, read_w[0], 1);
      advance();
      for (int k = 0; k < 80; k++) begin
         sample(1);
         chk("b2b_tx",   0, tx_w[0],   (k < 40) ? f01[k / 4] : fff[(k - 40) / 4]);
         chk("b2b_read", 0, read_w[0], (k == 39));
         advance();
      end
      idle_check(0, 3);

      // Reset during data bit 3 of 0x5A; 0x33 follows intact
      push(0, 8'h5A);
      push(0, 8'h33);
      sample(1);
      chk("mid_pop", 0, read_w[0], 1);
      advance();
      for (int k = 0; k < 18; k++) begin
         sample(1);
         chk("mid_tx", 0, tx_w[0], f5a[k / 4]);
         advance();
      end
      areset = 1'b1;
      sample(1);
      chk("mid_rst_read", 0, read_w[0], 0);
      advance();
      areset = 1'b0;
      sample(1);
      chk("post_rst_tx",   0, tx_w[0],   1);
      chk("post_rst_busy", 0, busy_w[0], 0);
      chk("post_rst_read", 0, read_w[0], 1);
      advance();
      for (int k = 0; k < 40; k++) begin
         sample(1);
         chk("after_rst_tx", 0, tx_w[0], f33[k / 4]);
         advance();
      end
      idle_check(0, 3);

      // Randomized traffic and occasional resets against the model
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 47) == 0) push(0, 8'($urandom));
         if ($urandom_range(0, 11) == 0) push(1, 8'($urandom));
         areset = ($urandom_range(0, 299) == 0);
         sample(1);
         advance();
      end
      areset = 1'b0;

      // Drain, bounded
      guard = 0;
      while ((q0.size() != 0 || q1.size() != 0 || active[0] || active[1]) && guard < 5000) begin
         sample(1);
         advance();
         guard++;
      end
      chk("drain_bound", 0, (guard < 5000), 1);
      for (int i = 0; i < 2; i++) begin
         sample(1);
         chk("final_tx",   i, tx_w[i],   1);
         chk("final_busy", i, busy_w[i], 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Read-side consumer for `fifo`. Drains words from the FIFO read port and shifts each one out on a single-wire asynchronous serial line (start bit, data LSB first, stop bit), with a programmable bit period. It sits between `fifo`'s `read`/`read_data`/`empty` and the board-level transmit pin. Frames go out back-to-back with no idle gap while the FIFO holds data.

## Interface
Parameters:
- `bits_per_word`, default 8: data bits per frame. Must equal the attached `fifo` `bits_per_word`.
- `clks_per_bit`, default 4: clock cycles per serial bit. Legal range is at least 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `areset`  in  1  reset; synchronous, active-high.
- `empty`  in  1  FIFO empty flag.
- `read_data`  in  `bits_per_word`  FIFO head word. First-word-fall-through: valid whenever `empty`=0.
- `read`  out  1  FIFO pop strobe. Combinational; the FIFO advances on the `clk` edge where `read`=1.
- `tx`  out  1  serial line; idles high. Registered.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE). Registered-state decode.
- `frame_done`  out  1  single-cycle strobe during the final stop-bit cycle of every frame.

## Operation
- States: IDLE, START, DATA, STOP.
- Internal registers:
  - `shift` (`bits_per_word` bits)
  - `bit_cnt`: counts 0..`bits_per_word`-1
  - `tick_cnt`: counts 0..`clks_per_bit`-1. Widths are sized with `$clog2`, minimum 1 bit.
- `read` = ~`areset` & ~`empty` & (state==IDLE | last_stop_cycle).
  - last_stop_cycle = state==STOP & `tick_cnt`==`clks_per_bit`-1.
- On any edge where `read`=1:
  - `shift` ← `read_data`
  - `tick_cnt` ← 0
  - `bit_cnt` ← 0
  - state ← START
- START: `tx`=0 for `clks_per_bit` cycles, then DATA.
- DATA: `tx`=`shift`[0]. When `tick_cnt` wraps:
  - `shift` shifts right by 1.
  - `bit_cnt` increments.
  - After bit `bits_per_word`-1, state → STOP.
- STOP: `tx`=1 for `clks_per_bit` cycles. At the last cycle:
  - If `empty`=0, the next word is popped and the block goes directly to START.
  - Otherwise it goes to IDLE.
- `frame_done` = last_stop_cycle, regardless of `empty`.
- `tx` is driven from a register updated with the state, so `tx` changes exactly on bit boundaries with no glitches.
- `empty`/`read_data` are ignored outside IDLE and last_stop_cycle.
  - A word written mid-frame is taken at the next frame boundary.
- A FIFO that transitions to `empty`=1 during a frame does not affect the frame in flight.

## Timing
- Reset values (state after any edge with `areset`=1):
  - state IDLE
  - `tx`=1, `busy`=0, `frame_done`=0
  - `read`=0, forced combinationally while `areset`=1
  - all counters 0
- Latency: if `empty` falls at edge E (block in IDLE):
  - `read`=1 in the cycle following E.
  - `tx` goes low from the next edge, E+1.
- Frame length: exactly (`bits_per_word`+2)·`clks_per_bit` cycles of `tx` activity.
- Back-to-back frames: the start bit of frame N+1 immediately follows the last stop cycle of frame N. Inter-frame gap is 0 cycles.
- At most one `read` pulse per frame. `read` is never asserted while `empty`=1.
- `clks_per_bit`=1: every state lasts exactly one cycle per bit. The last stop cycle is the only STOP cycle.
- Reset mid-frame:
  - `tx`=1 and state=IDLE after the reset edge.
  - The word already popped is discarded, not re-read.
  - On the first cycle after reset deasserts, `read` may assert if `empty`=0.

## Test plan
- Idle hold: `empty`=1 for 100 cycles after reset → `tx`=1, `read`=0, `busy`=0 throughout.
- Single word (8 bits, `clks_per_bit`=4): FIFO holds 0xA5 → one `read` pulse. `tx` carries bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total. `frame_done` pulses once at cycle 39. Then IDLE with `tx`=1.
- Back-to-back: FIFO holds 0x01 then 0xFF → `read` pulses at cycle 0 and cycle 39. `tx` forms 80 contiguous frame cycles with no idle gap between the stop bit and the next start bit. `empty` rises after the second pop.
- Late arrival: FIFO empty at the end of frame 0x3C; 0x81 written 5 cycles later → IDLE for those cycles with `tx`=1. 0x81 starts on the cycle after `empty` falls.
- Reset mid-frame: `areset` pulsed during the DATA bit 3 of 0x5A → `tx`=1 and `busy`=0 on the next edge, no further `read` for 0x5A. The following FIFO word is transmitted intact.
- `clks_per_bit`=1: FIFO holds 0x80 → 10-cycle frame 0,0,0,0,0,0,0,0,1,1.
